priority_encoder_seq: RTL

PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

---
 rtl/enc_pkg.sv | 26 ++
 rtl/prio_enc8.sv | 22 ++
 rtl/priority_encoder_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants, state encoding and index/code helpers for the
// sequential priority encoder.
package enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Pending bit k encodes to code 7-k, the inverse of the 3-to-8 decoder.
  function automatic logic [CODE_W-1:0] bit_to_code(input int k);
    return CODE_W'(N_REQ - 1 - k);
  endfunction

  // One-hot pending bit that a given code refers to.
  function automatic logic [N_REQ-1:0] code_to_mask(input logic [CODE_W-1:0] c);
    logic [N_REQ-1:0] m;
    m = '0;
    m[N_REQ - 1 - int'(c)] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder; bit 7 has the highest priority.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [7:0] vec,
  output logic       any,
  output logic [2:0] code
);

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    any  = 1'b0;
    code = '0;
    for (int k = 0; k < 8; k++) begin
      if (vec[k]) begin
        any  = 1'b1;
        code = bit_to_code(k);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: collects requests into a pending register
// and hands them out one code at a time over a valid/ready handshake.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | nothing offered; code held at 0
// VALID | code holds an offered request awaiting ready
module priority_encoder_seq
  import enc_pkg::*;
#(
  parameter int N_REQ  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow
);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                ovf_q, ovf_d;

  logic [N_REQ-1:0]    req_en;
  logic [N_REQ-1:0]    acc_mask;
  logic [N_REQ-1:0]    rem;
  logic                acc;
  logic                pend_any, rem_any;
  logic [CODE_W-1:0]   pend_code, rem_code;

  // Pick the next code from the whole register when idle, and from what
  // survives the current acceptance when handing out back-to-back.
  prio_enc8 u_enc_pending (
    .vec  (pending_q),
    .any  (pend_any),
    .code (pend_code)
  );

  prio_enc8 u_enc_rem (
    .vec  (rem),
    .any  (rem_any),
    .code (rem_code)
  );

  // Handshake, acceptance mask and the pending/overflow next values.
  always_comb begin
    req_en    = req & {N_REQ{en}};
    acc       = (state_q == VALID) && ready;
    acc_mask  = acc ? code_to_mask(code_q) : '0;
    rem       = pending_q & ~acc_mask;
    // Fresh captures are ORed in after the accepted bit is removed, so a
    // request landing on the bit being accepted survives as a new request.
    pending_d = rem | req_en;
    ovf_d     = |(req_en & rem);
  end

  // Next state and next offered code. New captures are not visible in rem,
  // so they are served no earlier than the following cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pend_any) begin
          state_d = VALID;
          code_d  = pend_code;
        end
      end
      VALID: begin
        if (ready) begin
          if (rem_any) begin
            code_d = rem_code;
          end else begin
            state_d = IDLE;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
  end

  // State, pending and output registers; clear flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid    = (state_q == VALID);
  assign code     = code_q;
  assign pending  = pending_q;
  assign overflow = ovf_q;

endmodule
